// File: rtl/rr_arb_2_1_pkg.sv
// rtl/rr_arb_2_1_pkg.sv - state encodings and tie-break helper shared by the 2:1 round-robin arbiter
package rr_arb_2_1_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic gnt;
      logic idx;
   } pick_t;

   // last_win is the previous winner; on a tie the other input is chosen
   function automatic pick_t arb_pick(input logic v0, input logic v1, input logic last_win);
      pick_t p;
      p.gnt = v0 | v1;
      p.idx = (v0 & v1) ? ~last_win : v1;
      return p;
   endfunction

endpackage

// File: rtl/mux_2_1_bus.sv
// rtl/mux_2_1_bus.sv - W-bit 2:1 bus steering, sel_i=0 picks a_i
module mux_2_1_bus #(
   parameter int W = 9
) (
   input  logic         sel_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);

   assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/rr_arb_2_1.sv
// rtl/rr_arb_2_1.sv - two-input round-robin packet arbiter holding grant until last beat
// ARB_STATS_EN adds saturating per-input packet counters pkt_cnt0/pkt_cnt1.
module rr_arb_2_1
   import rr_arb_2_1_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in0_valid,
   output logic              in0_ready,
   input  logic [DATA_W-1:0] in0_data,
   input  logic              in0_last,
   input  logic              in1_valid,
   output logic              in1_ready,
   input  logic [DATA_W-1:0] in1_data,
   input  logic              in1_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              sel,
   output logic              busy
`ifdef ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]  pkt_cnt0,
   output logic [CNT_W-1:0]  pkt_cnt1
`endif
);

   arb_state_e state_q, state_d;
   logic       sel_q, sel_d;
   logic       ptr_q, ptr_d;
   logic       last_hs;
   pick_t      pick;
   logic [DATA_W:0] mux_y;

   mux_2_1_bus #(.W(DATA_W + 1)) u_mux (
      .sel_i (sel_q),
      .a_i   ({in0_last, in0_data}),
      .b_i   ({in1_last, in1_data}),
      .y_o   (mux_y)
   );

   assign sel      = sel_q;
   assign busy     = (state_q != ST_IDLE);
   assign out_data = busy ? mux_y[DATA_W-1:0] : '0;
   assign out_last = busy & mux_y[DATA_W];
   assign last_hs  = out_valid & out_ready & out_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= 1'b0;
         ptr_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      out_valid = 1'b0;
      in0_ready = 1'b0;
      in1_ready = 1'b0;
      state_d   = state_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      // after a last beat the current owner becomes the new priority pointer
      pick      = arb_pick(in0_valid, in1_valid, (state_q == ST_IDLE) ? ptr_q : sel_q);
      case (state_q)
         ST_GNT0: begin
            out_valid = in0_valid;
            in0_ready = out_ready;
         end
         ST_GNT1: begin
            out_valid = in1_valid;
            in1_ready = out_ready;
         end
         default: ;
      endcase
      if (last_hs)
         ptr_d = sel_q;
      if ((state_q == ST_IDLE) || last_hs) begin
         if (pick.gnt) begin
            state_d = pick.idx ? ST_GNT1 : ST_GNT0;
            sel_d   = pick.idx;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

`ifdef ARB_STATS_EN
   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (last_hs) begin
         if (!sel_q && (cnt0_q != '1))
            cnt0_q <= cnt0_q + 1'b1;
         if (sel_q && (cnt1_q != '1))
            cnt1_q <= cnt1_q + 1'b1;
      end
   end

   assign pkt_cnt0 = cnt0_q;
   assign pkt_cnt1 = cnt1_q;
`else
   logic [CNT_W-1:0] stats_unused;
   assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_rr_arb_2_1.sv
// tb/tb_rr_arb_2_1.sv - directed bench for rr_arb_2_1; ARB_STATS_EN also checks counters
module tb_rr_arb_2_1;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in0_valid, in0_last, in1_valid, in1_last, out_ready;
   logic [DW-1:0] in0_data, in1_data;
   logic          in0_ready, in1_ready, out_valid, out_last, sel, busy;
   logic [DW-1:0] out_data;
   int            tests = 0;
   int            fails = 0;

`ifdef ARB_STATS_EN
   logic [15:0]   pkt_cnt0, pkt_cnt1;
   logic          s_in0_ready, s_in1_ready, s_out_valid, s_out_last, s_sel, s_busy;
   logic [DW-1:0] s_out_data;
   logic [1:0]    s_cnt0, s_cnt1;
`endif

   always #5 clk = ~clk;

   rr_arb_2_1 #(.DATA_W(DW), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_data  (in0_data),
      .in0_last  (in0_last),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_data  (in1_data),
      .in1_last  (in1_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .sel       (sel),
      .busy      (busy)
`ifdef ARB_STATS_EN
      ,
      .pkt_cnt0  (pkt_cnt0),
      .pkt_cnt1  (pkt_cnt1)
`endif
   );

`ifdef ARB_STATS_EN
   rr_arb_2_1 #(.DATA_W(DW), .CNT_W(2)) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .in0_valid (in0_valid),
      .in0_ready (s_in0_ready),
      .in0_data  (in0_data),
      .in0_last  (in0_last),
      .in1_valid (in1_valid),
      .in1_ready (s_in1_ready),
      .in1_data  (in1_data),
      .in1_last  (in1_last),
      .out_valid (s_out_valid),
      .out_ready (out_ready),
      .out_data  (s_out_data),
      .out_last  (s_out_last),
      .sel       (s_sel),
      .busy      (s_busy),
      .pkt_cnt0  (s_cnt0),
      .pkt_cnt1  (s_cnt1)
   );
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      {in0_valid, in0_last, in1_valid, in1_last, out_ready} = '0;
      in0_data = '0;
      in1_data = '0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sel", sel, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("idle_hold_busy", busy, 0);

      // tie: single-beat packets on both inputs, grants alternate without bubbles
      in0_valid = 1'b1; in0_last = 1'b1; in0_data = 8'h10;
      in1_valid = 1'b1; in1_last = 1'b1; in1_data = 8'h20;
      out_ready = 1'b1;
      #1;
      chk("idle_out_valid", out_valid, 0);
      chk("idle_in0_ready", in0_ready, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("tie_sel", sel, i % 2);
         chk("tie_out_valid", out_valid, 1);
         chk("tie_out_data", out_data, (i % 2) ? 8'h20 : 8'h10);
         chk("tie_loser_ready", (i % 2) ? in0_ready : in1_ready, 0);
      end

      // asynchronous reset mid-packet
      rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in0_ready", in0_ready, 0);
      chk("arst_in1_ready", in1_ready, 0);
      chk("arst_sel", sel, 0);
      chk("arst_busy", busy, 0);
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      tick();
      rst = 1'b0;

      // hold: 3-beat packet on in0 while in1 waits
      in0_valid = 1'b1; in0_last = 1'b0; in0_data = 8'hA1;
      in1_valid = 1'b1; in1_last = 1'b1; in1_data = 8'h55;
      tick();
      chk("hold_sel0", sel, 0);
      chk("hold_data_a1", out_data, 8'hA1);
      chk("hold_in0_ready", in0_ready, 1);
      chk("hold_in1_ready_a1", in1_ready, 0);
      tick();
      in0_data = 8'hA2;
      #1;
      chk("hold_data_a2", out_data, 8'hA2);
      chk("hold_in1_ready_a2", in1_ready, 0);

      // backpressure mid-packet
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_data", out_data, 8'hA2);
         chk("bp_in0_ready", in0_ready, 0);
         chk("bp_in1_ready", in1_ready, 0);
         chk("bp_busy", busy, 1);
         chk("bp_sel", sel, 0);
      end
      out_ready = 1'b1;
      tick();
      in0_data = 8'hA3;
      in0_last = 1'b1;
      #1;
      chk("hold_last", out_last, 1);
      chk("hold_in1_ready_a3", in1_ready, 0);
      tick();
      chk("hold_switch_sel", sel, 1);
      chk("hold_switch_data", out_data, 8'h55);
      chk("hold_switch_in1_ready", in1_ready, 1);
      chk("hold_switch_in0_ready", in0_ready, 0);

      // solo: in1 sends back-to-back packets, grant retained
      in0_valid = 1'b0;
      tick();
      in1_data = 8'h66;
      #1;
      chk("solo_sel", sel, 1);
      chk("solo_out_valid", out_valid, 1);
      chk("solo_data", out_data, 8'h66);
      tick();
      in1_valid = 1'b0;
      #1;
      chk("solo_end_sel", sel, 1);
      chk("solo_end_out_valid", out_valid, 0);
      tick();
      chk("solo_after_sel", sel, 1);

`ifdef ARB_STATS_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("cnt0_reset", pkt_cnt0, 0);
      in0_valid = 1'b1; in0_last = 1'b1;
      in1_valid = 1'b1; in1_last = 1'b1;
      out_ready = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) tick();
      in1_valid = 1'b0;
      #1;
      tick();
      tick();
      in0_valid = 1'b0;
      #1;
      chk("cnt0", pkt_cnt0, 5);
      chk("cnt1", pkt_cnt1, 3);
      chk("cnt0_sat", s_cnt0, 3);
      chk("cnt1_sat", s_cnt1, 3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
